melody_sequencer: RTL and testbench

Note-sequencing controller for the square-wave tone path on the 12 MHz board clock. It holds a small writable song table of (half-period, duration) entries. On `start` it plays the entries in order: for each entry it generates the speaker square wave for the programmed duration in millisecond ticks, inserts a fixed silent gap, and then advances. It sits between the button/control logic and the speaker pin. It replaces free-running single-tone generation with timed, restartable melodies.

---
 rtl/melody_sequencer.sv | 175 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Plays a writable table of (half-period, duration) entries as a timed square wave with a silent gap after each entry.
// Latency: start -> LOAD next cycle -> PLAY the cycle after; first note rise comes half cycles into PLAY.
// No backpressure: start/wr_en are ignored while busy, and stop aborts to IDLE on the next edge.
`timescale 1ns/1ps
module melody_sequencer #(
  parameter int DEPTH     = 16,
  parameter int HALF_W    = 16,
  parameter int DUR_W     = 10,
  parameter int TICK_DIV  = 12000,
  parameter int GAP_TICKS = 20,
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk12MHz,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [HALF_W-1:0] wr_half,
  input  logic [DUR_W-1:0]  wr_dur,
  output logic              note,
  output logic              tone_en,
  output logic [ADDR_W-1:0] note_idx,
  output logic              busy,
  output logic              done
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t             state_q;
  logic [HALF_W-1:0]  half_mem_q [DEPTH];
  logic [DUR_W-1:0]   dur_mem_q  [DEPTH];
  logic [HALF_W-1:0]  half_q, tog_q;
  logic [DUR_W-1:0]   dur_q, tick_q;
  logic [PRE_W-1:0]   pre_q;
  logic [GAP_W-1:0]   gap_q;
  logic [ADDR_W-1:0]  note_idx_q, idx_d;
  logic               end_q, end_d;
  logic               note_q, tone_en_q, busy_q, done_q;
  logic [HALF_W-1:0]  rd_half_d;
  logic [DUR_W-1:0]   rd_dur_d;
  logic               tick_d;

  assign note     = note_q;
  assign tone_en  = tone_en_q;
  assign note_idx = note_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Song table: writable only while idle, never cleared by reset
  always_ff @(posedge clk12MHz) begin
    if (wr_en && state_q == S_IDLE) begin
      half_mem_q[wr_addr] <= wr_half;
      dur_mem_q[wr_addr]  <= wr_dur;
    end
  end

  // Entry advance: past the last entry we latch an end flag instead of wrapping the index
  always_comb begin
    rd_half_d = half_mem_q[note_idx_q];
    rd_dur_d  = dur_mem_q[note_idx_q];
    tick_d    = (pre_q == PRE_LAST);
    idx_d     = note_idx_q;
    end_d     = end_q;
    if (note_idx_q == IDX_LAST) end_d = 1'b1;
    else                        idx_d = note_idx_q + ADDR_W'(1);
  end

  // Sequencer FSM with registered outputs; stop overrides every state
  always_ff @(posedge clk12MHz) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      note_q     <= 1'b0;
      tone_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      note_idx_q <= '0;
      end_q      <= 1'b0;
      half_q     <= '0;
      dur_q      <= '0;
      tog_q      <= '0;
      tick_q     <= '0;
      pre_q      <= '0;
      gap_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q   <= S_IDLE;
        note_q    <= 1'b0;
        tone_en_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q    <= S_LOAD;
              busy_q     <= 1'b1;
              note_idx_q <= '0;
              end_q      <= 1'b0;
            end
          end
          S_LOAD: begin
            half_q <= rd_half_d;
            dur_q  <= rd_dur_d;
            pre_q  <= '0;
            tick_q <= '0;
            tog_q  <= '0;
            gap_q  <= '0;
            note_q <= 1'b0;
            if (end_q || rd_dur_d == '0) begin
              if (loop && note_idx_q != '0) begin
                note_idx_q <= '0;
                end_q      <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              state_q   <= S_PLAY;
              tone_en_q <= (rd_half_d != '0);
            end
          end
          S_PLAY: begin
            pre_q <= tick_d ? '0 : pre_q + PRE_W'(1);
            if (tick_d) tick_q <= tick_q + DUR_W'(1);
            if (half_q != '0) begin
              if (tog_q == half_q - HALF_W'(1)) begin
                tog_q  <= '0;
                note_q <= ~note_q;
              end else begin
                tog_q <= tog_q + HALF_W'(1);
              end
            end
            // Last cycle of the entry: silence wins over a coincident toggle
            if (tick_d && tick_q == dur_q - DUR_W'(1)) begin
              note_q    <= 1'b0;
              tone_en_q <= 1'b0;
              tick_q    <= '0;
              tog_q     <= '0;
              if (GAP_TICKS == 0) begin
                state_q    <= S_LOAD;
                note_idx_q <= idx_d;
                end_q      <= end_d;
              end else begin
                state_q <= S_GAP;
              end
            end
          end
          S_GAP: begin
            pre_q <= tick_d ? '0 : pre_q + PRE_W'(1);
            if (tick_d) begin
              if (gap_q == GAP_LAST) begin
                state_q    <= S_LOAD;
                note_idx_q <= idx_d;
                end_q      <= end_d;
              end else begin
                gap_q <= gap_q + GAP_W'(1);
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_DIV=10, GAP_TICKS=1.
// Expected song statistics are queued when a song is launched and popped when it ends.
// Inputs change and outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_melody_sequencer;

  logic        clk12MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_half = '0;
  logic [9:0]  wr_dur = '0;
  logic        note, tone_en, busy, done;
  logic [3:0]  note_idx;

  melody_sequencer #(
    .DEPTH(16), .HALF_W(16), .DUR_W(10), .TICK_DIV(10), .GAP_TICKS(1)
  ) dut (
    .clk12MHz(clk12MHz), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_half(wr_half), .wr_dur(wr_dur),
    .note(note), .tone_en(tone_en), .note_idx(note_idx), .busy(busy), .done(done)
  );

  always #5 clk12MHz = ~clk12MHz;

  typedef struct { string tag; int val; } exp_t;
  exp_t sb_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  int m_busy, m_tog, m_gmin, m_gmax, m_rise, m_tone, m_idx1note, m_done_end, m_done_extra, m_end_idx;

  task automatic step();
    @(posedge clk12MHz);
    #1;
  endtask

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag, input int obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s: observed %0d expected <nothing queued>", tag, obs);
    end else begin
      e = sb_q.pop_front();
      compare({e.tag, "/", tag}, obs, e.val);
    end
  endtask

  task automatic push_song(input int b, input int tg, input int gmn, input int gmx, input int rs,
                           input int tn, input int i1, input int de, input int dx, input int ei);
    sb_push("busy_cycles", b);  sb_push("toggles", tg);   sb_push("gap_min", gmn);
    sb_push("gap_max", gmx);    sb_push("first_rise", rs); sb_push("tone_cycles", tn);
    sb_push("idx1_note", i1);   sb_push("done_at_end", de); sb_push("done_extra", dx);
    sb_push("end_idx", ei);
  endtask

  task automatic check_song();
    sb_check("busy_cycles", m_busy);  sb_check("toggles", m_tog);    sb_check("gap_min", m_gmin);
    sb_check("gap_max", m_gmax);      sb_check("first_rise", m_rise); sb_check("tone_cycles", m_tone);
    sb_check("idx1_note", m_idx1note); sb_check("done_at_end", m_done_end);
    sb_check("done_extra", m_done_extra); sb_check("end_idx", m_end_idx);
  endtask

  task automatic write_entry(input int a, input int h, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_half = 16'(h); wr_dur = 10'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Watches one song from the sample after the start edge until busy drops.
  // inject_at >= 0 drives start plus a write to entry 0 at that sample.
  task automatic monitor_song(input int inject_at);
    int t = 0;
    int last_t = -1;
    logic prev = note;
    m_busy = 0; m_tog = 0; m_gmin = 1000; m_gmax = 0; m_rise = -1;
    m_tone = 0; m_idx1note = 0; m_done_extra = 0;
    while (busy === 1'b1 && t < 2000) begin
      m_busy++;
      if (tone_en === 1'b1) m_tone++;
      if (note === 1'b1 && note_idx === 4'd1) m_idx1note++;
      if (note !== prev && tone_en === 1'b1) begin
        m_tog++;
        if (last_t >= 0) begin
          if (t - last_t < m_gmin) m_gmin = t - last_t;
          if (t - last_t > m_gmax) m_gmax = t - last_t;
        end
        last_t = t;
      end
      if (note === 1'b1 && m_rise < 0) m_rise = t;
      if (done === 1'b1) m_done_extra++;
      prev = note;
      if (t == inject_at) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_half = 16'd2; wr_dur = 10'd1;
      end
      step();
      start = 1'b0; wr_en = 1'b0;
      t++;
    end
    if (busy !== 1'b0) m_busy = -1;
    if (m_tog < 2) m_gmin = 0;
    m_done_end = (done === 1'b1) ? 1 : 0;
    m_end_idx = int'(note_idx);
    repeat (3) begin
      step();
      if (done === 1'b1) m_done_extra++;
    end
  endtask

  task automatic basic_table();
    write_entry(0, 4, 3);
    write_entry(1, 0, 2);
    write_entry(2, 7, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int dcnt;
    // Reset state
    step(); step();
    compare("rst_note", 32'(note), 0);
    compare("rst_tone_en", 32'(tone_en), 0);
    compare("rst_busy", 32'(busy), 0);
    compare("rst_done", 32'(done), 0);
    compare("rst_note_idx", 32'(note_idx), 0);
    rst_n = 1'b1;
    step();

    // 1. Basic song
    basic_table();
    push_song(73, 7, 4, 4, 5, 30, 0, 1, 0, 2);
    pulse_start();
    monitor_song(-1);
    check_song();

    // 2. Loop, then stop
    loop = 1'b1;
    sb_push("loop_idx2_sample", 72);
    pulse_start();
    t = 0; dcnt = 0;
    while (note_idx !== 4'd2 && t < 500) begin
      if (done === 1'b1) dcnt++;
      step(); t++;
    end
    sb_check("loop_idx2_sample", t);
    step();
    compare("loop_idx_back", 32'(note_idx), 0);
    compare("loop_busy", 32'(busy), 1);
    repeat (20) begin
      if (done === 1'b1) dcnt++;
      step();
    end
    compare("loop_tone_replay", 32'(tone_en), 1);
    compare("loop_no_done", dcnt, 0);
    stop = 1'b1; step(); stop = 1'b0;
    compare("loop_stop_busy", 32'(busy), 0);
    compare("loop_stop_note", 32'(note), 0);
    compare("loop_stop_done", 32'(done), 0);
    loop = 1'b0;
    step();

    // 3. Stop mid-note, then restart from e0
    sb_push("stop_rise_sample", 5);
    pulse_start();
    t = 0;
    while (note !== 1'b1 && t < 200) begin step(); t++; end
    sb_check("stop_rise_sample", t);
    stop = 1'b1; step(); stop = 1'b0;
    compare("stop_note", 32'(note), 0);
    compare("stop_tone_en", 32'(tone_en), 0);
    compare("stop_busy", 32'(busy), 0);
    compare("stop_done", 32'(done), 0);
    compare("stop_idx_hold", 32'(note_idx), 0);
    step();
    push_song(73, 7, 4, 4, 5, 30, 0, 1, 0, 2);
    pulse_start();
    monitor_song(-1);
    check_song();

    // 4. start and wr_en while busy are ignored
    push_song(73, 7, 4, 4, 5, 30, 0, 1, 0, 2);
    pulse_start();
    monitor_song(10);
    check_song();
    push_song(73, 7, 4, 4, 5, 30, 0, 1, 0, 2);
    pulse_start();
    monitor_song(-1);
    check_song();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    compare("start_stop_busy", 32'(busy), 0);
    step();
    compare("start_stop_busy_later", 32'(busy), 0);

    // 5a. Empty song never loops; done two cycles after start
    loop = 1'b1;
    write_entry(0, 4, 0);
    push_song(1, 0, 0, 0, -1, 0, 0, 1, 0, 0);
    pulse_start();
    monitor_song(-1);
    check_song();
    loop = 1'b0;

    // 5b. half=1 toggles every cycle
    write_entry(0, 1, 2);
    write_entry(1, 9, 0);
    push_song(32, 19, 1, 1, 2, 20, 0, 1, 0, 1);
    pulse_start();
    monitor_song(-1);
    check_song();

    // 5c. Full table: ends after the last entry with the index held there
    for (int i = 0; i < 16; i++) write_entry(i, 2, 1);
    push_song(337, 64, 2, 15, 3, 160, 4, 1, 0, 15);
    pulse_start();
    monitor_song(-1);
    check_song();

    // 6. Reset mid-play keeps the table
    basic_table();
    pulse_start();
    repeat (50) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    compare("mid_rst_note", 32'(note), 0);
    compare("mid_rst_tone_en", 32'(tone_en), 0);
    compare("mid_rst_busy", 32'(busy), 0);
    compare("mid_rst_done", 32'(done), 0);
    compare("mid_rst_note_idx", 32'(note_idx), 0);
    step();
    push_song(73, 7, 4, 4, 5, 30, 0, 1, 0, 2);
    pulse_start();
    monitor_song(-1);
    check_song();

    compare("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
